// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command-side initiator for the 16-bit ALU.
//
// Collects a 5-byte frame (FUN, A_lo, A_hi, B_lo, B_hi) from the RX byte
// stream, issues it to the ALU with a one-cycle ALU_EN pulse, captures the
// registered ALU result, and returns it over the valid/ready TX port
// (low byte first). If no ALU_OUT_VALID arrives within WAIT_MAX cycles of
// ALU_EN, a single ERR_BYTE is sent instead and ERR pulses for one cycle.
//
// Optional build macro:
//   ALU_SEQ_FLAG_BYTE_EN - append a third response byte
//                          {4'b0, ARITH, LOGIC, CMP, SHIFT}.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RX_DATA/RX_VALID/RX_READY  command byte input (accepted on VALID&&READY)
//   ALU_A, ALU_B, ALU_FUN    operands / function, stable from ISSUE onward
//   ALU_EN                   one-cycle issue pulse
//   ALU_OUT, ALU_OUT_VALID   ALU result and its valid strobe
//   ARITH/LOGIC/CMP/SHIFT_FLAG  ALU class flags, captured with the result
//   TX_DATA/TX_VALID/TX_READY  response byte output
//   BUSY                     high whenever not IDLE
//   ERR                      one-cycle pulse on result timeout
module alu_cmd_seq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned WAIT_MAX   = 8,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic                  ARITH_FLAG,
  input  logic                  LOGIC_FLAG,
  input  logic                  CMP_FLAG,
  input  logic                  SHIFT_FLAG,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned FLG_W  = 4;
  localparam int unsigned CNT_W  = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_A_LO = 4'd1,
    S_GET_A_HI = 4'd2,
    S_GET_B_LO = 4'd3,
    S_GET_B_HI = 4'd4,
    S_ISSUE    = 4'd5,
    S_WAIT_RES = 4'd6,
    S_TX_LO    = 4'd7,
    S_TX_HI    = 4'd8,
`ifdef ALU_SEQ_FLAG_BYTE_EN
    S_TX_FLG   = 4'd10,
`endif
    S_TX_ERR   = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [FLG_W-1:0]      flg_q, flg_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      wait_cnt_inc;
  logic                  rx_ready_q, rx_ready_d;
  logic                  alu_en_q, alu_en_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  rx_acc;
  logic                  tx_hs;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      wait_cnt_q <= '0;
      rx_ready_q <= 1'b1;
      alu_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
      wait_cnt_q <= wait_cnt_d;
      rx_ready_q <= rx_ready_d;
      alu_en_q   <= alu_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state, datapath updates, and registered-output decode
  always_comb begin
    state_d      = state_q;
    fun_d        = fun_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    res_d        = res_q;
    flg_d        = flg_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = 1'b0;
    rx_ready_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_data_d    = '0;
    tx_valid_d   = 1'b0;
    busy_d       = 1'b1;
    rx_acc       = RX_VALID && rx_ready_q;
    tx_hs        = tx_valid_q && TX_READY;
    wait_cnt_inc = CNT_W'(wait_cnt_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          fun_d   = RX_DATA[FUN_WIDTH-1:0];
          state_d = S_GET_A_LO;
        end
      end
      S_GET_A_LO: begin
        if (rx_acc) begin
          a_d     = {a_q[DATA_WIDTH-1:BYTE_W], RX_DATA};
          state_d = S_GET_A_HI;
        end
      end
      S_GET_A_HI: begin
        if (rx_acc) begin
          a_d     = {RX_DATA, a_q[BYTE_W-1:0]};
          state_d = S_GET_B_LO;
        end
      end
      S_GET_B_LO: begin
        if (rx_acc) begin
          b_d     = {b_q[DATA_WIDTH-1:BYTE_W], RX_DATA};
          state_d = S_GET_B_HI;
        end
      end
      S_GET_B_HI: begin
        // Frame complete: publish the whole command to the ALU at once
        if (rx_acc) begin
          b_d       = {RX_DATA, b_q[BYTE_W-1:0]};
          alu_a_d   = a_q;
          alu_b_d   = {RX_DATA, b_q[BYTE_W-1:0]};
          alu_fun_d = fun_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // A result always wins over a coincident timeout. The decision is
        // taken one count early because ERR is registered; this lands the
        // ERR pulse exactly WAIT_MAX cycles after ALU_EN.
        if (ALU_OUT_VALID) begin
          res_d   = ALU_OUT;
          flg_d   = {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};
          state_d = S_TX_LO;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == CNT_W'(WAIT_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = S_TX_ERR;
          end
        end
      end
      S_TX_LO: begin
        if (tx_hs) state_d = S_TX_HI;
      end
      S_TX_HI: begin
`ifdef ALU_SEQ_FLAG_BYTE_EN
        if (tx_hs) state_d = S_TX_FLG;
`else
        if (tx_hs) state_d = S_IDLE;
`endif
      end
`ifdef ALU_SEQ_FLAG_BYTE_EN
      S_TX_FLG: begin
        if (tx_hs) state_d = S_IDLE;
      end
`endif
      S_TX_ERR: begin
        if (tx_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step
    case (state_d)
      S_IDLE: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_GET_A_LO, S_GET_A_HI, S_GET_B_LO, S_GET_B_HI: begin
        rx_ready_d = 1'b1;
      end
      S_ISSUE: begin
        alu_en_d = 1'b1;
      end
      S_TX_LO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_d[BYTE_W-1:0];
      end
      S_TX_HI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_d[2*BYTE_W-1:BYTE_W];
      end
`ifdef ALU_SEQ_FLAG_BYTE_EN
      S_TX_FLG: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {4'b0000, flg_q};
      end
`endif
      S_TX_ERR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ERR_BYTE;
      end
      default: begin
        rx_ready_d = 1'b0;
      end
    endcase
  end

  assign RX_READY = rx_ready_q;
  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_FUN  = alu_fun_q;
  assign ALU_EN   = alu_en_q;
  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Command-side initiator for the 16-bit ALU.
- Collects a 5-byte command frame from a byte stream: FUN, A_lo, A_hi, B_lo, B_hi.
- Drives ALU operands, function and enable, then captures the registered ALU result.
- Returns the result as bytes over a valid/ready transmit port. Sits between the byte-level link (UART RX/TX side) and the ALU.

Parameters:
- DATA_WIDTH, 16, ALU operand/result width; fixed at 16 (two bytes per operand).
- FUN_WIDTH, 4, ALU function code width.
- WAIT_MAX, 8, max cycles to wait for ALU_OUT_VALID after ALU_EN before timeout.
- ERR_BYTE, 8'hEE, byte sent on timeout.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- RX_DATA  in  8  command byte.
- RX_VALID  in  1  RX_DATA valid, single-cycle per byte.
- RX_READY  out  1  high in frame-collect states; a byte is accepted only when RX_VALID and RX_READY are both high.
- ALU_A  out  16  operand A.
- ALU_B  out  16  operand B.
- ALU_FUN  out  4  function code.
- ALU_EN  out  1  one-cycle issue pulse.
- ALU_OUT  in  16  ALU result.
- ALU_OUT_VALID  in  1  result valid.
- ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  in  1 each  ALU class flags.
- TX_DATA  out  8  response byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  consumer accepts the byte when TX_VALID && TX_READY.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: every output is 0, except RX_READY=1. State=IDLE. Holding registers and the wait counter are cleared. A synchronous RST mid-frame or mid-transmit aborts immediately; a partially collected frame is discarded.
- States: IDLE, GET_A_LO, GET_A_HI, GET_B_LO, GET_B_HI, ISSUE, WAIT_RES, TX_LO, TX_HI, [TX_FLG], TX_ERR.
- IDLE: an accepted byte latches FUN = RX_DATA[3:0]; bits [7:4] are ignored. Go to GET_A_LO.
- GET_* states: each accepted byte fills the named half of A or B and advances. GET_B_HI goes to ISSUE. Cycles without RX_VALID hold the state; there is no inter-byte timeout.
- RX_READY is high only in IDLE and GET_*. Bytes arriving in other states are dropped and not buffered.
- ISSUE: ALU_EN=1 for exactly one cycle; go to WAIT_RES with the wait counter cleared.
- ALU_A, ALU_B and ALU_FUN update only when the frame completes. They hold stable from ISSUE until the next frame completes.
- All 16 codes are issued unmodified, including 4'b1111 (NO_FUN).
- WAIT_RES:
  - When ALU_OUT_VALID=1, capture ALU_OUT and the 4 flags, then go to TX_LO.
  - Otherwise increment the counter. If the counter reaches WAIT_MAX without ALU_OUT_VALID, go to TX_ERR and pulse ERR for 1 cycle.
  - If ALU_OUT_VALID arrives on the same cycle the counter reaches WAIT_MAX, the result wins.
  - Latency: the registered ALU gives ALU_OUT_VALID one cycle after ALU_EN, so the first TX_VALID occurs 2 cycles after ALU_EN.
- TX_LO: TX_DATA = result[7:0], TX_VALID=1. Data is held stable until TX_READY. The handshake goes to TX_HI.
- TX_HI: same, with result[15:8]. The handshake goes to IDLE (or TX_FLG).
- TX_ERR: TX_DATA = ERR_BYTE until handshake, then IDLE. No result bytes are sent.
- TX_VALID never drops without a handshake except on RST. TX_VALID=0 in all non-TX states. TX_DATA=0 when TX_VALID=0.
- Back-to-back: a new FUN byte is accepted on the cycle after returning to IDLE. The IDLE-entry cycle itself has RX_READY=1.

Optional Feature:
- ALU_SEQ_FLAG_BYTE_EN defined: after TX_HI, state TX_FLG sends {4'b0, ARITH, LOGIC, CMP, SHIFT} as captured, then goes to IDLE. A response is 3 bytes.
- Undefined: TX_FLG does not exist. A response is 2 bytes, and flags are captured but unused.

Test Plan:
- Frame 00,0F,00,0A,00 with the ALU modelled as registered, TX_READY=1 -> ALU_EN pulse, ALU_A=15, ALU_B=10, ALU_FUN=0. TX bytes 0x19 then 0x00. With the macro defined, a third byte 0x08. BUSY falls after the last byte.
- Frame F1,0F,00,0A,00 (upper nibble ignored; SUB) -> ALU_FUN=1, TX 0x05,0x00. Same frame with FUN=0E and A=0x0009 -> TX 0x12,0x00. With the macro, flag byte 0x01.
- Backpressure: TX_READY low for 3 cycles during TX_LO -> TX_VALID=1 and TX_DATA=0x19 stable for all 3 cycles. Then 0x00 follows. Extra RX bytes during this window are dropped; RX_READY=0.
- Timeout: ALU_OUT_VALID tied low -> ERR pulse exactly WAIT_MAX=8 cycles after ALU_EN. TX byte 0xEE, then IDLE. A following valid frame completes normally.
- Reset mid-operation: RST=1 for 1 cycle after the A_hi byte -> all outputs 0, RX_READY=1, IDLE. Next 5 bytes 04,09,00,03,00 form a fresh frame -> TX 0x01,0x00.
- Boundary: ALU_OUT_VALID on the same cycle as counter=WAIT_MAX with ALU_OUT=0xFFFE -> no ERR. TX 0xFE,0xFF.
